// File: rtl/bus_slave_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | bus_slave_pkg : shared constants and FSM encoding for burst slave  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package bus_slave_pkg;

    localparam int c_DATA_W  = 32;
    localparam int c_BE_W    = 4;
    localparam int c_BURST_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WRITE      = 3'd1,
        ST_READ_FETCH = 3'd2,
        ST_READ       = 3'd3,
        ST_READ_END   = 3'd4,
        ST_ERROR      = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/bus_slave_sram.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | bus_slave_sram : single-port sync RAM, 1-cycle read, byte writes   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module bus_slave_sram
    import bus_slave_pkg::*;
#(
    parameter int ADDR_BITS = 10
) (
    input  logic                 clock,
    input  logic [ADDR_BITS-1:0] i_addr,
    input  logic                 i_we,
    input  logic [c_BE_W-1:0]    i_be,
    input  logic [c_DATA_W-1:0]  i_wdata,
    input  logic                 i_re,
    output logic [c_DATA_W-1:0]  o_rdata
);

    logic [c_DATA_W-1:0] r_mem [2**ADDR_BITS];
    logic [c_DATA_W-1:0] r_rdata;

    always_ff @(posedge clock) begin
        if (i_we) begin
            for (int b = 0; b < c_BE_W; b++) begin
                if (i_be[b]) begin
                    r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
        if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/bus_burst_slave_mem.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | bus_burst_slave_mem : burst-bus responder backed by on-chip RAM    |
// | Option: BUS_SLAVE_RANGE_ERROR_EN flags bursts running off the end. |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module bus_burst_slave_mem
    import bus_slave_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR     = 32'h5000_0000,
    parameter int          MEM_ADDR_BITS = 10
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 beginTransactionIn,
    input  logic [c_DATA_W-1:0]  addressDataIn,
    input  logic [c_BE_W-1:0]    byteEnablesIn,
    input  logic [c_BURST_W-1:0] burstSizeIn,
    input  logic                 readNotWriteIn,
    input  logic                 dataValidIn,
    input  logic                 endTransactionIn,
    output logic [c_DATA_W-1:0]  addressDataOut,
    output logic                 dataValidOut,
    output logic                 endTransactionOut,
    output logic                 busErrorOut
);

    localparam int c_TAG_LSB = MEM_ADDR_BITS + 2;

    state_t                   r_state;
    state_t                   w_next;
    logic [MEM_ADDR_BITS-1:0] r_ptr;
    logic [c_BURST_W-1:0]     r_cnt;
    logic [c_BE_W-1:0]        r_be;
    logic                     r_wr_done;

    logic                     w_sel;
    logic [MEM_ADDR_BITS-1:0] w_start_ptr;
    logic                     w_ram_we;
    logic                     w_ram_re;
    logic [c_DATA_W-1:0]      w_rdata;
    logic                     w_err;

    assign w_sel       = beginTransactionIn &&
                         (addressDataIn[31:c_TAG_LSB] == BASE_ADDR[31:c_TAG_LSB]);
    assign w_start_ptr = addressDataIn[MEM_ADDR_BITS+1:2];

`ifdef BUS_SLAVE_RANGE_ERROR_EN
    localparam int c_SUM_W = MEM_ADDR_BITS + c_BURST_W + 1;
    logic [c_SUM_W-1:0] w_end_word;
    logic               w_range_fault;
    assign w_end_word    = c_SUM_W'(w_start_ptr) + c_SUM_W'(burstSizeIn);
    assign w_range_fault = |w_end_word[c_SUM_W-1:MEM_ADDR_BITS];
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next            = r_state;
        w_ram_we          = 1'b0;
        w_ram_re          = 1'b0;
        w_err             = 1'b0;
        dataValidOut      = 1'b0;
        endTransactionOut = 1'b0;
        addressDataOut    = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_sel) begin
`ifdef BUS_SLAVE_RANGE_ERROR_EN
                    if (w_range_fault) begin
                        w_next = ST_ERROR;
                    end else
`endif
                    if (readNotWriteIn) begin
                        w_next = ST_READ_FETCH;
                    end else begin
                        w_next = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                // A beat coinciding with end is still committed.
                w_ram_we = dataValidIn && !r_wr_done;
                if (endTransactionIn) begin
                    w_next = ST_IDLE;
                end
            end
            ST_READ_FETCH: begin
                w_ram_re = 1'b1;
                w_next   = endTransactionIn ? ST_IDLE : ST_READ;
            end
            ST_READ: begin
                dataValidOut   = 1'b1;
                addressDataOut = w_rdata;
                w_ram_re       = 1'b1;
                if (endTransactionIn) begin
                    w_next = ST_IDLE;
                end else if (r_cnt == '0) begin
                    w_next = ST_READ_END;
                end
            end
            ST_READ_END: begin
                endTransactionOut = 1'b1;
                w_next            = ST_IDLE;
            end
            ST_ERROR: begin
                endTransactionOut = 1'b1;
                w_err             = 1'b1;
                w_next            = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

`ifdef BUS_SLAVE_RANGE_ERROR_EN
    assign busErrorOut = w_err;
`else
    assign busErrorOut = 1'b0;
`endif

    // Pointer wraps naturally through its MEM_ADDR_BITS width.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_ptr     <= '0;
            r_cnt     <= '0;
            r_be      <= '0;
            r_wr_done <= 1'b0;
        end else begin
            if (r_state == ST_IDLE && w_sel) begin
                r_ptr     <= w_start_ptr;
                r_cnt     <= burstSizeIn;
                r_be      <= byteEnablesIn;
                r_wr_done <= 1'b0;
            end else if (w_ram_we || w_ram_re) begin
                r_ptr <= r_ptr + 1'b1;
            end
            if (w_ram_we) begin
                if (r_cnt == '0) begin
                    r_wr_done <= 1'b1;
                end else begin
                    r_cnt <= r_cnt - 1'b1;
                end
            end
            if (r_state == ST_READ && r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    bus_slave_sram #(
        .ADDR_BITS (MEM_ADDR_BITS)
    ) u_sram (
        .clock   (clock),
        .i_addr  (r_ptr),
        .i_we    (w_ram_we),
        .i_be    (r_be),
        .i_wdata (addressDataIn),
        .i_re    (w_ram_re),
        .o_rdata (w_rdata)
    );

endmodule
`default_nettype wire
